// File: rtl/fifo_rd_adapt_pkg.sv
// Shared constants and helpers for the FIFO read-port to valid/ready stream adapter.
package fifo_rd_adapt_pkg;

    localparam int RD_LAT_COMB = 1;
    localparam int RD_LAT_REG  = 2;
    localparam int BEAT_CNT_W  = 32;

    // Enough entries to cover every in-flight read plus one-beat/cycle overlap.
    function automatic int buf_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

    function automatic int level_w(input int rd_lat);
        return $clog2(buf_depth(rd_lat) + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// FIFO read-port and stream-side signals of fifo_rd_stream_adapter.
interface fifo_rd_stream_adapter_if
    import fifo_rd_adapt_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int RD_LAT = RD_LAT_COMB
) ();

    localparam int LEVEL_W = level_w(RD_LAT);

    logic                  i_empty;
    logic                  o_ren;
    logic [DWIDTH-1:0]     i_rdata;
    logic                  o_valid;
    logic [DWIDTH-1:0]     o_data;
    logic                  i_ready;
    logic [LEVEL_W-1:0]    o_level;
    logic [BEAT_CNT_W-1:0] o_beat_cnt;

    modport master (
        input  i_empty, i_rdata, i_ready,
        output o_ren, o_valid, o_data, o_level, o_beat_cnt
    );

    modport slave (
        output i_empty, i_rdata, i_ready,
        input  o_ren, o_valid, o_data, o_level, o_beat_cnt
    );

endinterface

// File: rtl/rd_lat_pipe.sv
// In-flight read tracker: one bit per outstanding pop, bit RD_LAT-1 marks a returning word.
module rd_lat_pipe
    import fifo_rd_adapt_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_COMB,
    localparam int INF_W = $clog2(RD_LAT + 1)
) (
    input  logic             i_clk_sys,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_ren,
    output logic             o_ret_valid,
    output logic [INF_W-1:0] o_inflight
);

    logic [RD_LAT-1:0] sr;
    logic [RD_LAT-1:0] sr_shift;

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign sr_shift = i_ren;
        end else begin : g_latn
            assign sr_shift = {sr[RD_LAT-2:0], i_ren};
        end
    endgenerate

    // Clearing on flush is what makes late returns from flushed pops vanish.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            sr <= '0;
        end else if (i_flush) begin
            sr <= '0;
        end else begin
            sr <= sr_shift;
        end
    end

    assign o_ret_valid = sr[RD_LAT-1];

    always_comb begin
        o_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            o_inflight = o_inflight + INF_W'(sr[i]);
        end
    end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the FIFO pop/latency read port into a credit-controlled valid/ready stream.
// Optional accepted-beat counter: define FIFO_RD_ADAPT_BEAT_CNT_EN.
module fifo_rd_stream_adapter
    import fifo_rd_adapt_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int RD_LAT = RD_LAT_COMB
) (
    input  logic                     i_clk_sys,
    input  logic                     i_rst,
    input  logic                     i_flush,
    fifo_rd_stream_adapter_if.master bus
);

    localparam int BUF_DEPTH = buf_depth(RD_LAT);
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int LEVEL_W   = $clog2(BUF_DEPTH + 1);
    localparam int INF_W     = $clog2(RD_LAT + 1);

    generate
        if (RD_LAT != RD_LAT_COMB && RD_LAT != RD_LAT_REG) begin : g_bad_rd_lat
            $error("fifo_rd_stream_adapter: RD_LAT must be 1 or 2");
        end
    endgenerate

    logic               rst_q;
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [LEVEL_W-1:0] count;
    logic [DWIDTH-1:0]  mem [BUF_DEPTH];
    logic               ret_valid;
    logic [INF_W-1:0]   inflight;
    logic [LEVEL_W:0]   credit_used;
    logic               ren;
    logic               valid;
    logic               xfer;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Keeps pops off for the first cycle after reset release.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            rst_q <= 1'b1;
        end else begin
            rst_q <= 1'b0;
        end
    end

    rd_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_lat_pipe (
        .i_clk_sys   (i_clk_sys),
        .i_rst       (i_rst),
        .i_flush     (i_flush),
        .i_ren       (ren),
        .o_ret_valid (ret_valid),
        .o_inflight  (inflight)
    );

    // Every pop owns a buffer slot from issue until its word is consumed.
    assign credit_used = {1'b0, count} + (LEVEL_W + 1)'(inflight);
    assign ren   = !rst_q && !bus.i_empty && !i_flush
                   && (credit_used < (LEVEL_W + 1)'(BUF_DEPTH));
    assign valid = (count != '0);
    assign xfer  = valid && bus.i_ready;

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (i_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (ret_valid) begin
                wptr <= ptr_inc(wptr);
            end
            if (xfer) begin
                rptr <= ptr_inc(rptr);
            end
            case ({ret_valid, xfer})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (ret_valid && !i_flush) begin
            mem[wptr] <= bus.i_rdata;
        end
    end

    assign bus.o_ren   = ren;
    assign bus.o_valid = valid;
    assign bus.o_data  = mem[rptr];
    assign bus.o_level = count;

`ifdef FIFO_RD_ADAPT_BEAT_CNT_EN
    logic [BEAT_CNT_W-1:0] beat_cnt;

    // Flush does not touch this; only reset does.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            beat_cnt <= '0;
        end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    assign bus.o_beat_cnt = beat_cnt;
`else
    assign bus.o_beat_cnt = '0;
`endif

endmodule
